// File: rtl/clk_div_monitor.sv
// Receive-side monitor for a divided clock: measures high/low/period lengths in
// clk cycles, tracks lock against an expected half-period and flags a stuck input.
module clk_div_monitor #(
  parameter int CNT_W    = 16,
  parameter int EXP_HALF = 5,
  parameter int TOL      = 1,
  parameter int LOCK_N   = 4,
  parameter int TIMEOUT  = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_in,
  output logic [CNT_W-1:0] high_len,
  output logic [CNT_W-1:0] low_len,
  output logic [CNT_W-1:0] period,
  output logic             meas_valid,
  output logic             locked,
  output logic             stuck,
  output logic [7:0]       err_count
);

  localparam int LO_I = (EXP_HALF > TOL) ? (EXP_HALF - TOL) : 0;
  localparam int HI_I = EXP_HALF + TOL;
  localparam int MC_W = $clog2(LOCK_N + 1);

  localparam logic [CNT_W-1:0] LO_B      = CNT_W'(LO_I);
  localparam logic [CNT_W-1:0] HI_B      = CNT_W'(HI_I);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [MC_W-1:0]  LOCK_C    = MC_W'(LOCK_N);

  typedef enum logic [1:0] {SYNC, HIGH, LOW} state_t;

  state_t           state_q, state_d;
  logic             s1_q, s2_q, s3_q;
  logic [CNT_W-1:0] ph_cnt_q, ph_cnt_d;
  logic [CNT_W-1:0] high_len_q, high_len_d;
  logic [CNT_W-1:0] low_len_q, low_len_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             meas_valid_q, meas_valid_d;
  logic             locked_q, locked_d;
  logic             stuck_q, stuck_d;
  logic [7:0]       err_count_q, err_count_d;
  logic [MC_W-1:0]  match_cnt_q, match_cnt_d;

  logic             rise, fall;
  logic             timeout_hit;
  logic             in_tol;
  logic [CNT_W-1:0] ph_inc;

  assign rise        = s2_q & ~s3_q;
  assign fall        = ~s2_q & s3_q;
  assign ph_inc      = (ph_cnt_q == '1) ? ph_cnt_q : ph_cnt_q + 1'b1;
  assign in_tol      = (high_len_q >= LO_B) && (high_len_q <= HI_B) &&
                       (ph_cnt_q >= LO_B) && (ph_cnt_q <= HI_B);

  always_comb begin
    state_d      = state_q;
    ph_cnt_d     = ph_cnt_q;
    high_len_d   = high_len_q;
    low_len_d    = low_len_q;
    period_d     = period_q;
    meas_valid_d = 1'b0;
    locked_d     = locked_q;
    stuck_d      = stuck_q;
    err_count_d  = err_count_q;
    match_cnt_d  = match_cnt_q;
    timeout_hit  = 1'b0;

    case (state_q)
      SYNC: begin
        if (rise) begin
          state_d  = HIGH;
          ph_cnt_d = CNT_W'(1);
          stuck_d  = 1'b0;
        end
      end
      HIGH: begin
        if (fall) begin
          high_len_d = ph_cnt_q;
          ph_cnt_d   = CNT_W'(1);
          state_d    = LOW;
        end else if (ph_cnt_q >= TIMEOUT_C) begin
          timeout_hit = 1'b1;
        end else begin
          ph_cnt_d = ph_inc;
        end
      end
      LOW: begin
        if (rise) begin
          low_len_d    = ph_cnt_q;
          period_d     = high_len_q + ph_cnt_q;
          meas_valid_d = 1'b1;
          ph_cnt_d     = CNT_W'(1);
          state_d      = HIGH;
          if (in_tol) begin
            match_cnt_d = (match_cnt_q == LOCK_C) ? match_cnt_q : match_cnt_q + 1'b1;
            locked_d    = (match_cnt_d == LOCK_C);
          end else begin
            match_cnt_d = '0;
            locked_d    = 1'b0;
            err_count_d = (err_count_q == 8'hFF) ? err_count_q : err_count_q + 8'd1;
          end
        end else if (ph_cnt_q >= TIMEOUT_C) begin
          timeout_hit = 1'b1;
        end else begin
          ph_cnt_d = ph_inc;
        end
      end
      default: state_d = SYNC;
    endcase

    // A stuck input drops lock but keeps the last good measurements visible.
    if (timeout_hit) begin
      stuck_d     = 1'b1;
      locked_d    = 1'b0;
      match_cnt_d = '0;
      ph_cnt_d    = '0;
      state_d     = SYNC;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= SYNC;
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      s3_q         <= 1'b0;
      ph_cnt_q     <= '0;
      high_len_q   <= '0;
      low_len_q    <= '0;
      period_q     <= '0;
      meas_valid_q <= 1'b0;
      locked_q     <= 1'b0;
      stuck_q      <= 1'b0;
      err_count_q  <= '0;
      match_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      s1_q         <= clk_in;
      s2_q         <= s1_q;
      s3_q         <= s2_q;
      ph_cnt_q     <= ph_cnt_d;
      high_len_q   <= high_len_d;
      low_len_q    <= low_len_d;
      period_q     <= period_d;
      meas_valid_q <= meas_valid_d;
      locked_q     <= locked_d;
      stuck_q      <= stuck_d;
      err_count_q  <= err_count_d;
      match_cnt_q  <= match_cnt_d;
    end
  end

  assign high_len   = high_len_q;
  assign low_len    = low_len_q;
  assign period     = period_q;
  assign meas_valid = meas_valid_q;
  assign locked     = locked_q;
  assign stuck      = stuck_q;
  assign err_count  = err_count_q;

endmodule

// File: tb/tb_clk_div_monitor.sv
// Self-checking bench for clk_div_monitor: directed and random divided-clock
// waveforms compared cycle by cycle against a timestamp-based reference model.
module tb_clk_div_monitor;

  localparam int CNT_W    = 16;
  localparam int EXP_HALF = 5;
  localparam int TOL      = 1;
  localparam int LOCK_N   = 4;
  localparam int TIMEOUT  = 64;
  localparam int LO_OK    = (EXP_HALF > TOL) ? (EXP_HALF - TOL) : 0;
  localparam int HI_OK    = EXP_HALF + TOL;

  logic             clk = 1'b0;
  logic             reset;
  logic             clk_in;
  logic [CNT_W-1:0] high_len;
  logic [CNT_W-1:0] low_len;
  logic [CNT_W-1:0] period;
  logic             meas_valid;
  logic             locked;
  logic             stuck;
  logic [7:0]       err_count;

  int errors = 0;
  int checks = 0;

  clk_div_monitor #(
    .CNT_W(CNT_W), .EXP_HALF(EXP_HALF), .TOL(TOL), .LOCK_N(LOCK_N), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .clk_in(clk_in),
    .high_len(high_len), .low_len(low_len), .period(period),
    .meas_valid(meas_valid), .locked(locked), .stuck(stuck), .err_count(err_count)
  );

  always #5 clk = ~clk;

  // Reference model: edges become visible a fixed number of clk edges after
  // the input changes; lengths are differences between edge timestamps.
  bit inHist[4];
  int cyc;
  bit running, inHigh;
  int lastEdge;
  int mHigh, mLow, mPer, mErr, goodRun;
  bit mValid, mLocked, mStuck;

  task automatic modelReset();
    for (int i = 0; i < 4; i++) inHist[i] = 1'b0;
    running = 0; inHigh = 0; lastEdge = 0;
    mHigh = 0; mLow = 0; mPer = 0; mErr = 0; goodRun = 0;
    mValid = 0; mLocked = 0; mStuck = 0;
  endtask

  task automatic modelStep();
    bit seenRise, seenFall;
    int len;
    cyc++;
    if (reset) begin
      modelReset();
      return;
    end
    inHist[3] = inHist[2];
    inHist[2] = inHist[1];
    inHist[1] = inHist[0];
    inHist[0] = clk_in;
    seenRise = inHist[2] && !inHist[3];
    seenFall = !inHist[2] && inHist[3];
    mValid = 0;
    if (!running) begin
      if (seenRise) begin
        running = 1; inHigh = 1; lastEdge = cyc; mStuck = 0;
      end
    end else begin
      len = cyc - lastEdge;
      if (inHigh && seenFall) begin
        mHigh = len; inHigh = 0; lastEdge = cyc;
      end else if (!inHigh && seenRise) begin
        mLow = len;
        mPer = (mHigh + len) % (1 << CNT_W);
        mValid = 1; inHigh = 1; lastEdge = cyc;
        if (mHigh >= LO_OK && mHigh <= HI_OK && mLow >= LO_OK && mLow <= HI_OK) begin
          goodRun++;
          mLocked = (goodRun >= LOCK_N);
        end else begin
          goodRun = 0;
          mLocked = 0;
          if (mErr < 255) mErr++;
        end
      end else if (len >= TIMEOUT) begin
        mStuck = 1; mLocked = 0; goodRun = 0; running = 0;
      end
    end
  endtask

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at cycle %0d: observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic checkOutput();
    checkVal("meas_valid", 32'(meas_valid), 32'(mValid));
    checkVal("locked",     32'(locked),     32'(mLocked));
    checkVal("stuck",      32'(stuck),      32'(mStuck));
    checkVal("err_count",  32'(err_count),  32'(mErr));
    checkVal("high_len",   32'(high_len),   32'(mHigh));
    checkVal("low_len",    32'(low_len),    32'(mLow));
    checkVal("period",     32'(period),     32'(mPer));
  endtask

  task automatic cycle();
    @(posedge clk);
    modelStep();
    #1;
    checkOutput();
  endtask

  task automatic applyStimulus(input bit lvl, input int n);
    clk_in = lvl;
    repeat (n) cycle();
  endtask

  task automatic runPeriods(input int hi, input int lo, input int n);
    repeat (n) begin
      applyStimulus(1'b1, hi);
      applyStimulus(1'b0, lo);
    end
  endtask

  initial begin
    int hi, lo;
    cyc = 0;
    modelReset();
    reset  = 1'b1;
    clk_in = 1'b0;
    repeat (4) cycle();
    reset = 1'b0;

    // Nominal 5/5 divider: locks after the fourth measurement.
    runPeriods(5, 5, 8);
    checkVal("nominal_locked", 32'(locked), 32'd1);
    checkVal("nominal_high",   32'(high_len), 32'd5);
    checkVal("nominal_period", 32'(period), 32'd10);
    checkVal("nominal_err",    32'(err_count), 32'd0);

    runPeriods(7, 7, 5);
    runPeriods(4, 6, 6);
    runPeriods(3, 7, 2);

    // Relock, then freeze the input high long enough to trip the timeout.
    runPeriods(5, 5, 6);
    applyStimulus(1'b1, 80);
    checkVal("stuck_flag",   32'(stuck), 32'd1);
    checkVal("stuck_unlock", 32'(locked), 32'd0);
    runPeriods(5, 5, 7);

    // Reset pulse in the middle of a low phase.
    applyStimulus(1'b1, 5);
    applyStimulus(1'b0, 3);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    checkVal("midreset_period", 32'(period), 32'd0);
    checkVal("midreset_err",    32'(err_count), 32'd0);
    applyStimulus(1'b0, 4);
    runPeriods(5, 5, 6);

    // Random phase lengths with occasional stalls.
    repeat (40) begin
      hi = int'($urandom_range(2, 9));
      lo = int'($urandom_range(2, 9));
      runPeriods(hi, lo, 1);
      if ($urandom_range(0, 7) == 0) applyStimulus(1'($urandom_range(0, 1)), 70);
    end

    // Enough bad periods to saturate the error counter.
    runPeriods(2, 2, 260);
    applyStimulus(1'b1, 6);
    checkVal("err_saturated", 32'(err_count), 32'd255);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
